// File: rtl/screen_state_ctrl.sv
// Screen controller: debounced start switch, TITLE/PLAYING/GAME_OVER FSM, pixel select and 12-bit VGA output register.
// Define TITLE_BLINK_EN to blink the title text; without it TITLE always shows title_rgb.
module screen_state_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_FRAMES    = 30,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        start_sw,
    input  logic        game_over,
    input  logic [4:0]  title_rgb,
    input  logic [4:0]  game_rgb,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        game_active,
    output logic        game_reset,
    output logic [1:0]  screen_state
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FMAX = (2 * BLINK_FRAMES > HOLD_FRAMES) ? 2 * BLINK_FRAMES : HOLD_FRAMES;
    localparam int FCW  = $clog2(FMAX + 1);

    typedef enum logic [1:0] {
        S_TITLE     = 2'b00,
        S_PLAYING   = 2'b01,
        S_GAME_OVER = 2'b10
    } state_e;

    logic           sync1_q, sync2_q;
    logic           sw_db_q, sw_db_d, sw_db_prev_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           sw_rise, sw_fall, frame_tick, blink_on;
    state_e         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           game_reset_q, game_reset_d, game_active_q;
    logic [4:0]     sel_rgb;
    logic [11:0]    rgb12_d, rgb12_q;

    // Counter only runs while the synced switch disagrees with the debounced value
    always_comb begin
        sw_db_d  = sw_db_q;
        db_cnt_d = '0;
        if (sync2_q != sw_db_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                sw_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign sw_rise    = sw_db_q & ~sw_db_prev_q;
    assign sw_fall    = ~sw_db_q & sw_db_prev_q;
    assign frame_tick = pixel_tick & (pixel_x == 11'd0) & (pixel_y == 11'd0);

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        game_reset_d = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (sw_rise) begin
                    state_d      = S_PLAYING;
                    game_reset_d = 1'b1;
                    frame_cnt_d  = '0;
                end else begin
`ifdef TITLE_BLINK_EN
                    if (frame_tick) begin
                        frame_cnt_d = (frame_cnt_q == FCW'(2 * BLINK_FRAMES - 1)) ? '0
                                                                                  : frame_cnt_q + 1'b1;
                    end
`else
                    frame_cnt_d = '0;
`endif
                end
            end
            S_PLAYING: begin
                frame_cnt_d = '0;
                if (sw_fall) begin
                    state_d = S_TITLE;
                end else if (game_over) begin
                    state_d = S_GAME_OVER;
                end
            end
            S_GAME_OVER: begin
                // Leaving needs the full hold time and the switch already dropped
                if ((frame_cnt_q == FCW'(HOLD_FRAMES)) && !sw_db_q) begin
                    state_d     = S_TITLE;
                    frame_cnt_d = '0;
                end else if (frame_tick && (frame_cnt_q != FCW'(HOLD_FRAMES))) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = S_TITLE;
                frame_cnt_d = '0;
            end
        endcase
    end

`ifdef TITLE_BLINK_EN
    assign blink_on = (frame_cnt_q < FCW'(BLINK_FRAMES));
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin
        sel_rgb = 5'd0;
        case (state_q)
            S_TITLE:     sel_rgb = blink_on ? title_rgb : 5'd0;
            S_PLAYING:   sel_rgb = game_rgb;
            S_GAME_OVER: sel_rgb = game_rgb | 5'b10000;
            default:     sel_rgb = 5'd0;
        endcase
        rgb12_d = video_on ? {sel_rgb[4:3], sel_rgb[4:3], sel_rgb[2:1], sel_rgb[2:1], {4{sel_rgb[0]}}}
                           : 12'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sw_db_q       <= 1'b0;
            sw_db_prev_q  <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= S_TITLE;
            frame_cnt_q   <= '0;
            game_reset_q  <= 1'b0;
            game_active_q <= 1'b0;
            rgb12_q       <= 12'd0;
        end else begin
            sync1_q       <= start_sw;
            sync2_q       <= sync1_q;
            sw_db_q       <= sw_db_d;
            sw_db_prev_q  <= sw_db_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            game_reset_q  <= game_reset_d;
            game_active_q <= (state_d == S_PLAYING);
            if (pixel_tick) begin
                rgb12_q <= rgb12_d;
            end
        end
    end

    assign vga_r        = rgb12_q[11:8];
    assign vga_g        = rgb12_q[7:4];
    assign vga_b        = rgb12_q[3:0];
    assign game_active  = game_active_q;
    assign game_reset   = game_reset_q;
    assign screen_state = state_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Self-checking bench for screen_state_ctrl with small debounce/blink/hold constants.
module tb_screen_state_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, pixel_tick, video_on, start_sw, game_over;
    logic [10:0] pixel_x, pixel_y;
    logic [4:0]  title_rgb, game_rgb;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        game_active, game_reset;
    logic [1:0]  screen_state;
    logic [11:0] vga;

    always #5 clk = ~clk;
    assign vga = {vga_r, vga_g, vga_b};

    screen_state_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_FRAMES   (2),
        .HOLD_FRAMES    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_tick  (pixel_tick),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .start_sw    (start_sw),
        .game_over   (game_over),
        .title_rgb   (title_rgb),
        .game_rgb    (game_rgb),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .game_active (game_active),
        .game_reset  (game_reset),
        .screen_state(screen_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int gr_total = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        vid;
        logic [4:0]  grgb;
        logic [11:0] expv;
    } vec_t;

    always @(negedge clk) begin
        if (game_reset === 1'b1) gr_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel_tick transaction; the expected colour rides the scoreboard queue
    task automatic px(input logic [10:0] x, input logic [10:0] y, input logic vid,
                      input logic [4:0] trgb, input logic [4:0] grgb, input logic [11:0] expv);
        pixel_x    = x;
        pixel_y    = y;
        video_on   = vid;
        title_rgb  = trgb;
        game_rgb   = grgb;
        pixel_tick = 1'b1;
        exp_q.push_back(expv);
        step();
        pixel_tick = 1'b0;
        if (exp_q.size() == 0) chk("vga_queue_empty", 32'd1, 32'd0);
        else chk("vga", 32'(vga), 32'(exp_q.pop_front()));
    endtask

    initial begin
        vec_t vt[6];
        int   lat;
        int   gr_snap;
        logic blink_en;
        logic on;
        logic [11:0] e;

`ifdef TITLE_BLINK_EN
        blink_en = 1'b1;
`else
        blink_en = 1'b0;
`endif
        // PLAYING colour vectors: {x, y, video_on, game_rgb, expected {R,G,B}}
        vt[0] = '{11'd5, 11'd1, 1'b1, 5'b11111, 12'hFFF};
        vt[1] = '{11'd6, 11'd1, 1'b0, 5'b11111, 12'h000};
        vt[2] = '{11'd7, 11'd1, 1'b1, 5'b01010, 12'h550};
        vt[3] = '{11'd1, 11'd2, 1'b1, 5'b00001, 12'h00F};
        vt[4] = '{11'd2, 11'd2, 1'b1, 5'b00000, 12'h000};
        vt[5] = '{11'd3, 11'd2, 1'b1, 5'b10101, 12'hAAF};

        rst_n = 1'b0; start_sw = 1'b1; game_over = 1'b0; pixel_tick = 1'b0;
        video_on = 1'b0; pixel_x = 11'd3; pixel_y = 11'd3; title_rgb = 5'd0; game_rgb = 5'd0;

        // 1: switch held high through reset
        repeat (3) step();
        chk("rst_state", 32'(screen_state), 32'd0);
        chk("rst_vga", 32'(vga), 32'd0);
        chk("rst_active", 32'(game_active), 32'd0);
        chk("rst_game_reset", 32'(game_reset), 32'd0);
        gr_snap = gr_total;
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && screen_state != 2'b01; i++) begin
            step();
            lat = i;
        end
        chk("start_state", 32'(screen_state), 32'd1);
        chk("start_latency_ok", 32'((lat >= 5) && (lat <= 9)), 32'd1);
        chk("start_active", 32'(game_active), 32'd1);
        repeat (3) step();
        chk("game_reset_pulses", 32'(gr_total - gr_snap), 32'd1);

        // 6: PLAYING colour table, then blanking/hold between ticks
        title_rgb = 5'b11111;
        foreach (vt[i]) px(vt[i].x, vt[i].y, vt[i].vid, 5'b11111, vt[i].grgb, vt[i].expv);
        px(11'd4, 11'd2, 1'b0, 5'b11111, 5'b11111, 12'h000);
        px(11'd5, 11'd2, 1'b1, 5'b11111, 5'b10101, 12'hAAF);
        video_on = 1'b0; game_rgb = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("vga_hold", 32'(vga), 32'hAAF);
        end

        // 3: game_over lands in the same clk as the debounced fall
        start_sw = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            game_over = (i == lat);
            step();
            if (i == lat - 1) chk("pre_fall_state", 32'(screen_state), 32'd1);
        end
        game_over = 1'b0;
        chk("fall_wins_state", 32'(screen_state), 32'd0);
        chk("fall_wins_active", 32'(game_active), 32'd0);

        // 4: game over with the switch dropped at once; hold for 3 frames
        start_sw = 1'b1;
        repeat (lat) step();
        chk("restart_state", 32'(screen_state), 32'd1);
        game_over = 1'b1; start_sw = 1'b0;
        step();
        game_over = 1'b0;
        chk("go_state", 32'(screen_state), 32'd2);
        chk("go_active", 32'(game_active), 32'd0);
        repeat (10) step();
        chk("go_hold_state", 32'(screen_state), 32'd2);
        // red tint sets r1, so game_rgb 00001 becomes R=A, G=0, B=F
        for (int k = 1; k <= 3; k++) begin
            px(11'd1, 11'd0, 1'b1, 5'd0, 5'b00001, 12'hA0F);
            px(11'd0, 11'd0, 1'b1, 5'd0, 5'b00001, 12'hA0F);
            chk("go_frame_state", 32'(screen_state), 32'd2);
        end
        step();
        chk("go_exit_state", 32'(screen_state), 32'd0);

        // 2: short glitch and a stray game_over in TITLE
        gr_snap = gr_total;
        start_sw = 1'b1;
        repeat (3) step();
        start_sw = 1'b0;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        repeat (10) step();
        chk("glitch_state", 32'(screen_state), 32'd0);
        chk("glitch_game_reset", 32'(gr_total - gr_snap), 32'd0);

        // 5: title blink (or steady text without the blink feature)
        for (int k = 0; k < 8; k++) begin
            on = blink_en ? ((k % 4) < 2) : 1'b1;
            e  = on ? 12'hF0F : 12'h000;
            px(11'd1, 11'd0, 1'b1, 5'b11001, 5'b11111, e);
            px(11'd2, 11'd0, 1'b0, 5'b11001, 5'b11111, 12'h000);
            px(11'd0, 11'd0, 1'b1, 5'b11001, 5'b11111, e);
        end

        // Reset in the middle of a game
        start_sw = 1'b1;
        repeat (lat) step();
        chk("mid_start_state", 32'(screen_state), 32'd1);
        px(11'd9, 11'd9, 1'b1, 5'd0, 5'b11111, 12'hFFF);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_state", 32'(screen_state), 32'd0);
        chk("mid_rst_vga", 32'(vga), 32'd0);
        chk("mid_rst_active", 32'(game_active), 32'd0);
        step();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
